// File: rtl/mio_bus_responder_if.sv
// mio_bus_responder_if: CPU memory/IO request/response handshake bundle
interface mio_bus_responder_if;
  logic        cpu_mio;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        mio_ready;
  modport master(output cpu_mio, cpu_we, cpu_addr, cpu_wdata, input cpu_rdata, mio_ready);
  modport slave(input cpu_mio, cpu_we, cpu_addr, cpu_wdata, output cpu_rdata, mio_ready);
endinterface

// File: rtl/mio_bus_responder.sv
// mio_bus_responder: MIO target for data RAM, LED, switches and optional cycle counter (MIO_COUNTER_EN)
module mio_bus_responder #(
  parameter int RAM_AW      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  mio_bus_responder_if.slave bus,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              we_q, we_n;
  logic              ready_q, ready_n;
  logic [31:0]       rdata_q, rdata_n;
  logic              ram_en_n, ram_we_n;
  logic [RAM_AW-1:0] ram_addr_n;
  logic [31:0]       ram_wdata_n;
  logic [15:0]       led_n;
  logic              is_ram, is_led, is_sw;
  logic [31:0]       cnt_rd, periph_rd;
  logic              unused_addr;
  assign unused_addr = ^bus.cpu_addr[1:0];
  assign is_ram = bus.cpu_addr[31:RAM_AW+2] == '0;
  assign is_led = bus.cpu_addr[31:2] == 30'h3800_0000;
  assign is_sw  = bus.cpu_addr[31:2] == 30'h3C00_0000;
`ifdef MIO_COUNTER_EN
  logic [31:0] cycles;
  // free-running cycle counter, sampled by CNT reads on the accept cycle
  always_ff @(posedge clk)
    cycles <= rst ? '0 : cycles + 32'd1;
  assign cnt_rd = bus.cpu_addr[31:2] == 30'h3C00_0001 ? cycles : '0;
`else
  assign cnt_rd = '0;
`endif
  assign periph_rd = is_led ? {16'h0, led_out} : is_sw ? {16'h0, sw_in} : cnt_rd;
  assign bus.mio_ready = ready_q;
  assign bus.cpu_rdata = rdata_q;
  // next state and next registered outputs; peripherals resolve at accept, RAM after the wait count
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    we_n        = we_q;
    ready_n     = 1'b0;
    rdata_n     = '0;
    ram_en_n    = 1'b0;
    ram_we_n    = 1'b0;
    ram_addr_n  = ram_addr;
    ram_wdata_n = ram_wdata;
    led_n       = led_out;
    if (state == IDLE && bus.cpu_mio) begin
      we_n        = bus.cpu_we;
      ram_addr_n  = bus.cpu_addr[RAM_AW+1:2];
      ram_wdata_n = bus.cpu_wdata;
      cnt_n       = 4'(WAIT_CYCLES - 1);
      state_n     = is_ram ? WAIT : RESP;
      ram_en_n    = is_ram;
      ram_we_n    = is_ram && bus.cpu_we;
      ready_n     = !is_ram;
      rdata_n     = (is_ram || bus.cpu_we) ? '0 : periph_rd;
      led_n       = (is_led && bus.cpu_we) ? bus.cpu_wdata[15:0] : led_out;
    end else if (state == WAIT) begin
      cnt_n   = cnt - 4'd1;
      state_n = cnt == 4'd0 ? RESP : WAIT;
      ready_n = cnt == 4'd0;
      rdata_n = (cnt == 4'd0 && !we_q) ? ram_rdata : '0;
    end else if (state == RESP) begin
      state_n = IDLE;
    end
  end
  // state and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      led_out   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      we_q      <= we_n;
      ready_q   <= ready_n;
      rdata_q   <= rdata_n;
      ram_en    <= ram_en_n;
      ram_we    <= ram_we_n;
      ram_addr  <= ram_addr_n;
      ram_wdata <= ram_wdata_n;
      led_out   <= led_n;
    end
endmodule

// File: tb/tb_mio_bus_responder.sv
// tb_mio_bus_responder: directed vector bench with a sync RAM model
module tb_mio_bus_responder;
  localparam int AW = 10;
  logic clk = 1'b0, rst = 1'b1;
  logic ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [15:0] sw_in, led_out;
  logic [31:0] mem [0:(1<<AW)-1];
  int n_chk = 0, n_fail = 0;
  mio_bus_responder_if bus();
  mio_bus_responder #(.RAM_AW(AW), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .sw_in(sw_in), .led_out(led_out));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (rst && !bus.cpu_mio) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
      ram_rdata <= '0;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rd, output logic en1, output logic we1,
                         output logic [AW-1:0] a1, output logic anywe, output logic leak);
    bus.cpu_mio = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    lat = 0; rd = '0; anywe = 1'b0; leak = 1'b0; en1 = 1'b0; we1 = 1'b0; a1 = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        en1 = ram_en; we1 = ram_we; a1 = ram_addr;
        bus.cpu_addr = ~addr; bus.cpu_wdata = ~wdata; bus.cpu_we = ~we;
      end
      anywe |= ram_we;
      if (bus.mio_ready) begin lat = k; rd = bus.cpu_rdata; break; end
      leak |= bus.cpu_rdata != 0;
    end
    bus.cpu_mio = 1'b0;
  endtask
  typedef struct {
    logic we; logic [31:0] addr; logic [31:0] wdata; logic [15:0] sw;
    int lat; logic [31:0] rd; logic [15:0] led; logic en1; logic [AW-1:0] a1;
  } vec_t;
  vec_t v [16];
  int lat;
  logic [31:0] rd, c1;
  logic en1, we1, anywe, leak;
  logic [AW-1:0] a1;
  initial begin
    v[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0000, 3, 32'h0,         16'h0000, 1'b1, 10'h004};
    v[1]  = '{1'b0, 32'h0000_0010, 32'h0,         16'h0000, 3, 32'hDEAD_BEEF, 16'h0000, 1'b1, 10'h004};
    v[2]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 16'h0000, 3, 32'h0,         16'h0000, 1'b1, 10'h3FF};
    v[3]  = '{1'b0, 32'h0000_0FFC, 32'h0,         16'h0000, 3, 32'hCAFE_F00D, 16'h0000, 1'b1, 10'h3FF};
    v[4]  = '{1'b0, 32'h0000_1000, 32'h0,         16'h0000, 1, 32'h0,         16'h0000, 1'b0, 10'h0};
    v[5]  = '{1'b1, 32'hE000_0000, 32'h1234_ABCD, 16'h0000, 1, 32'h0,         16'hABCD, 1'b0, 10'h0};
    v[6]  = '{1'b0, 32'hE000_0000, 32'h0,         16'h0000, 1, 32'h0000_ABCD, 16'hABCD, 1'b0, 10'h0};
    v[7]  = '{1'b0, 32'hF000_0000, 32'h0,         16'h00F0, 1, 32'h0000_00F0, 16'hABCD, 1'b0, 10'h0};
    v[8]  = '{1'b1, 32'hF000_0000, 32'hFFFF_FFFF, 16'h00F0, 1, 32'h0,         16'hABCD, 1'b0, 10'h0};
    v[9]  = '{1'b0, 32'h8000_0000, 32'h0,         16'h1234, 1, 32'h0,         16'hABCD, 1'b0, 10'h0};
    v[10] = '{1'b1, 32'h8000_0000, 32'h5555_5555, 16'h1234, 1, 32'h0,         16'hABCD, 1'b0, 10'h0};
    v[11] = '{1'b1, 32'h0000_1000, 32'h7777_7777, 16'h1234, 1, 32'h0,         16'hABCD, 1'b0, 10'h0};
    v[12] = '{1'b0, 32'h0000_0000, 32'h0,         16'h1234, 3, 32'h0,         16'hABCD, 1'b1, 10'h000};
    v[13] = '{1'b0, 32'h0000_0013, 32'h0,         16'h1234, 3, 32'hDEAD_BEEF, 16'hABCD, 1'b1, 10'h004};
    v[14] = '{1'b1, 32'hE000_0002, 32'h0000_5A5A, 16'h1234, 1, 32'h0,         16'h5A5A, 1'b0, 10'h0};
    v[15] = '{1'b0, 32'hF000_0002, 32'h0,         16'hBEEF, 1, 32'h0000_BEEF, 16'h5A5A, 1'b0, 10'h0};
    bus.cpu_mio = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; sw_in = '0;
    repeat (3) @(negedge clk);
    chk("reset mio_ready", {31'h0, bus.mio_ready}, 32'h0);
    chk("reset cpu_rdata", bus.cpu_rdata, 32'h0);
    chk("reset ram_en/we", {30'h0, ram_en, ram_we}, 32'h0);
    chk("reset led_out", {16'h0, led_out}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    foreach (v[i]) begin
      sw_in = v[i].sw;
      run_req(v[i].we, v[i].addr, v[i].wdata, lat, rd, en1, we1, a1, anywe, leak);
      chk($sformatf("v%0d latency", i), lat, v[i].lat);
      chk($sformatf("v%0d cpu_rdata", i), rd, v[i].rd);
      chk($sformatf("v%0d led_out", i), {16'h0, led_out}, {16'h0, v[i].led});
      chk($sformatf("v%0d ram_en cyc1", i), {31'h0, en1}, {31'h0, v[i].en1});
      chk($sformatf("v%0d ram_we cyc1", i), {31'h0, we1}, {31'h0, v[i].en1 & v[i].we});
      chk($sformatf("v%0d ram_we any", i), {31'h0, anywe}, {31'h0, v[i].en1 & v[i].we});
      chk($sformatf("v%0d rdata idle", i), {31'h0, leak}, 32'h0);
      if (v[i].en1) chk($sformatf("v%0d ram_addr", i), {22'h0, a1}, {22'h0, v[i].a1});
      @(negedge clk);
    end
    bus.cpu_mio = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h20; bus.cpu_wdata = 32'h1111_1111;
    @(negedge clk);
    chk("abort ram_en cyc1", {31'h0, ram_en}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort mio_ready", {31'h0, bus.mio_ready}, 32'h0);
    chk("abort ram strobes", {30'h0, ram_en, ram_we}, 32'h0);
    chk("abort ram_addr", {22'h0, ram_addr}, 32'h0);
    chk("abort ram_wdata", ram_wdata, 32'h0);
    chk("abort cpu_rdata", bus.cpu_rdata, 32'h0);
    chk("abort led_out", {16'h0, led_out}, 32'h0);
    rst = 1'b0;
    run_req(1'b1, 32'h20, 32'h1111_1111, lat, rd, en1, we1, a1, anywe, leak);
    chk("restart latency", lat, 3);
    chk("restart ram_we cyc1", {31'h0, we1}, 32'h1);
    chk("restart ram_addr", {22'h0, a1}, 32'h8);
    @(negedge clk);
    run_req(1'b0, 32'h20, 32'h0, lat, rd, en1, we1, a1, anywe, leak);
    chk("restart readback", rd, 32'h1111_1111);
    chk("restart readback latency", lat, 3);
    @(negedge clk);
    run_req(1'b0, 32'hF000_0004, 32'h0, lat, rd, en1, we1, a1, anywe, leak);
    chk("cnt latency", lat, 1);
    c1 = rd;
`ifdef MIO_COUNTER_EN
    repeat (4) @(negedge clk);
    run_req(1'b0, 32'hF000_0004, 32'h0, lat, rd, en1, we1, a1, anywe, leak);
    chk("cnt delta", rd - c1, 32'd5);
`else
    chk("cnt unmapped", c1, 32'h0);
`endif
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
